// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter slice.
// Optional feature macro: VRAM_RAW_FWD_EN (read-after-write forwarding from the write FIFO).
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W      = 15;
  localparam int unsigned VRAM_DATA_W      = 8;
  localparam int unsigned VRAM_WFIFO_DEPTH = 4;

  // Owner of the VRAM port in a given cycle
  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_DISP = 2'd1,
    G_WR   = 2'd2,
    G_RD   = 2'd3
  } grant_e;

  // One posted CPU write at the default widths
  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wfifo_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int unsigned wfifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_wfifo.sv
// Posted-write FIFO holding {addr, data} pairs for the VRAM arbiter.
// With VRAM_RAW_FWD_EN defined, all entries and the read pointer are exported
// so the arbiter can search them for read-after-write forwarding.
module vram_wfifo
  import vram_pkg::*;
#(
  parameter  int unsigned ADDR_W = VRAM_ADDR_W,
  parameter  int unsigned DATA_W = VRAM_DATA_W,
  parameter  int unsigned DEPTH  = VRAM_WFIFO_DEPTH,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = wfifo_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
`ifdef VRAM_RAW_FWD_EN
  ,
  output logic [ADDR_W-1:0] ent_addr_o [DEPTH],
  output logic [DATA_W-1:0] ent_data_o [DEPTH],
  output logic [PTR_W-1:0]  rd_ptr_o
`endif
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Status flags, guarded push/pop, and next pointer/count values
  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Head entry presented to the arbiter
  always_comb begin
    head_addr_o = addr_q[rd_ptr_q];
    head_data_o = data_q[rd_ptr_q];
  end

`ifdef VRAM_RAW_FWD_EN
  // Expose storage for forwarding lookups
  always_comb begin
    ent_addr_o = addr_q;
    ent_data_o = data_q;
    rd_ptr_o   = rd_ptr_q;
  end
`endif

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the valid window
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, then posted
// CPU writes from the FIFO, then the one held CPU read.
// Optional macro VRAM_RAW_FWD_EN: reads are accepted with a non-empty FIFO and
// are answered from the youngest matching FIFO entry without a VRAM access.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W      = VRAM_ADDR_W,
  parameter int unsigned DATA_W      = VRAM_DATA_W,
  parameter int unsigned WFIFO_DEPTH = VRAM_WFIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_req,
  input  logic [ADDR_W-1:0]            disp_addr,
  output logic [DATA_W-1:0]            disp_rdata,
  output logic                         disp_rvalid,
  input  logic                         cpu_valid,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_ready,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_rvalid,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(WFIFO_DEPTH):0] wfifo_count
);

  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
  localparam int unsigned CNT_W = wfifo_cnt_w(WFIFO_DEPTH);

  grant_e            grant_q, grant_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;

  logic              rd_ok, rd_accept, fwd_hit, fwd_take;
  logic [DATA_W-1:0] fwd_data;

`ifdef VRAM_RAW_FWD_EN
  logic [ADDR_W-1:0] ent_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] ent_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_rd_ptr;
  logic [PTR_W-1:0]  idx;
`endif

  vram_wfifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WFIFO_DEPTH)
  ) u_wfifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_addr_i (cpu_addr),
    .push_data_i (cpu_wdata),
    .pop_i       (fifo_pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
`ifdef VRAM_RAW_FWD_EN
    ,
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data),
    .rd_ptr_o    (fifo_rd_ptr)
`endif
  );

`ifdef VRAM_RAW_FWD_EN
  // Scan oldest to youngest so the last hit wins: that is the youngest write
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < WFIFO_DEPTH; i++) begin
      idx = fifo_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < fifo_count) && (ent_addr[idx] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
    rd_ok = !hold_valid_q;
  end
`else
  // Reads wait until no posted write could be newer than VRAM contents
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    rd_ok    = !hold_valid_q && fifo_empty;
  end
`endif

  // CPU handshake: writes need FIFO space, reads need the holding slot
  always_comb begin
    cpu_ready = !rst && (cpu_we ? !fifo_full : rd_ok);
    fifo_push = cpu_valid && cpu_we && cpu_ready;
    rd_accept = cpu_valid && !cpu_we && cpu_ready;
    fwd_take  = rd_accept && fwd_hit;
  end

  // Grant state register: remembers who owned the port last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= G_IDLE;
    end else begin
      grant_q <= grant_d;
    end
  end

  // Next grant: display, then FIFO head, then held read, then a fresh read
  always_comb begin
    grant_d = G_IDLE;
    if (rst) begin
      grant_d = G_IDLE;
    end else if (disp_req) begin
      grant_d = G_DISP;
    end else if (!fifo_empty) begin
      grant_d = G_WR;
    end else if (hold_valid_q) begin
      grant_d = G_RD;
    end else if (rd_accept && !fwd_take) begin
      grant_d = G_RD;
    end
  end

  // Grant outputs: VRAM port this cycle, return-data steering from last grant
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fifo_pop    = 1'b0;
    unique case (grant_d)
      G_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      G_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
        fifo_pop  = 1'b1;
      end
      G_RD: begin
        mem_en   = 1'b1;
        mem_addr = hold_valid_q ? hold_addr_q : cpu_addr;
      end
      default: ;
    endcase
    disp_rvalid = (grant_q == G_DISP);
    disp_rdata  = disp_rvalid ? mem_rdata : '0;
    cpu_rvalid  = (grant_q == G_RD) || fwd_valid_q;
    if (grant_q == G_RD) begin
      cpu_rdata = mem_rdata;
    end else if (fwd_valid_q) begin
      cpu_rdata = fwd_data_q;
    end else begin
      cpu_rdata = '0;
    end
    wfifo_count = fifo_count;
  end

  // Holding register: a read that cannot issue or forward now is parked here
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    if (grant_d == G_RD) begin
      hold_valid_d = 1'b0;
    end else if (rd_accept && !fwd_take) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = cpu_addr;
    end
    fwd_valid_d = fwd_take;
    fwd_data_d  = fwd_take ? fwd_data : '0;
  end

  // Read-side state registers; reset drops any parked or in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural VRAM and scoreboard queues.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [$clog2(DEPTH):0] wfifo_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_disp [$];
  logic [DW-1:0] exp_cpu  [$];
  wfifo_entry_t  exp_wr   [$];

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WFIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .wfifo_count (wfifo_count)
  );

  // VRAM model: preloaded with addr[7:0], one-cycle read latency
  logic [DW-1:0] vram [1 << AW];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < (1 << AW); a++) vram[a] <= 8'(a);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= vram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (exp_disp.size() == 0 && exp_cpu.size() == 0 && exp_wr.size() == 0 && wfifo_count == 0) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  // Scoreboard: display latency, display/CPU read data, write order
  task automatic run_monitor();
    logic         prev_disp;
    logic [DW-1:0] d;
    wfifo_entry_t e;
    forever begin
      @(posedge clk);
      prev_disp = disp_req && !rst;
      @(negedge clk);
      checks++;
      if (disp_rvalid !== (prev_disp && !rst)) begin
        errors++;
        $display("FAIL disp_rvalid_latency: got %b required %b at %0t", disp_rvalid, prev_disp && !rst, $time);
      end
      if (disp_rvalid === 1'b1) begin
        checks++;
        if (exp_disp.size() == 0) begin
          errors++;
          $display("FAIL disp_unexpected: got rdata %h required no rvalid at %0t", disp_rdata, $time);
        end else begin
          d = exp_disp.pop_front();
          if (disp_rdata !== d) begin
            errors++;
            $display("FAIL disp_rdata: got %h required %h at %0t", disp_rdata, d, $time);
          end
        end
      end
      if (cpu_rvalid === 1'b1) begin
        checks++;
        if (exp_cpu.size() == 0) begin
          errors++;
          $display("FAIL cpu_unexpected: got rdata %h required no rvalid at %0t", cpu_rdata, $time);
        end else begin
          d = exp_cpu.pop_front();
          if (cpu_rdata !== d) begin
            errors++;
            $display("FAIL cpu_rdata: got %h required %h at %0t", cpu_rdata, d, $time);
          end
        end
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got %h<=%h required no write at %0t", mem_addr, mem_wdata, $time);
        end else begin
          e = exp_wr.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("FAIL wr_order: got %h<=%h required %h<=%h at %0t", mem_addr, mem_wdata, e.addr, e.data, $time);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got en=%b we=%b a=%h d=%h required all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({cpu_ready, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rd: got rdy=%b crv=%b crd=%h drv=%b drd=%h required all 0", cpu_ready, cpu_rvalid, cpu_rdata, disp_rvalid, disp_rdata);
    end
    checks++;
    if (wfifo_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d required 0", wfifo_count);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_disp_fetch();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      disp_req  = 1'b1;
      disp_addr = 15'(32'h10 + i);
      exp_disp.push_back(8'(32'h10 + i));
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== disp_addr) begin
        errors++;
        $display("FAIL disp_issue: got en=%b we=%b a=%h required 1 0 %h", mem_en, mem_we, mem_addr, disp_addr);
      end
      step();
    end
    disp_req = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL disp_drain: got pending, required idle"); end
  endtask

  task automatic test_back_to_back();
    wfifo_entry_t e;
    bit ok;
    disp_req  = 1'b1;
    disp_addr = 15'h20;
    for (int k = 0; k < 5; k++) begin
      cpu_valid = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 15'(32'h300 + k);
      cpu_wdata = 8'(32'hA0 + k);
      exp_disp.push_back(8'h20);
      @(negedge clk);
      checks++;
      if (cpu_ready !== (k < 4)) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b required %b", k, cpu_ready, k < 4);
      end
      if (k < 4) begin
        e.addr = cpu_addr; e.data = cpu_wdata;
        exp_wr.push_back(e);
      end else begin
        checks++;
        if (wfifo_count !== 4) begin
          errors++;
          $display("FAIL b2b_full_count: got %0d required 4", wfifo_count);
        end
      end
      step();
    end
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'h300) begin
      errors++;
      $display("FAIL b2b_full_pop: got rdy=%b we=%b a=%h required 0 1 0300", cpu_ready, mem_we, mem_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_retry: got %b required 1", cpu_ready);
    end
    e.addr = cpu_addr; e.data = cpu_wdata;
    exp_wr.push_back(e);
    step();
    cpu_valid = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain: got pending, required idle"); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (vram[32'h300 + k] !== 8'(32'hA0 + k)) begin
        errors++;
        $display("FAIL b2b_vram%0d: got %h required %h", k, vram[32'h300 + k], 8'(32'hA0 + k));
      end
    end
  endtask

  task automatic test_write_then_read();
    wfifo_entry_t e;
    bit ok;
    disp_req  = 1'b1;
    disp_addr = 15'h21;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h100; cpu_wdata = 8'hAB;
    exp_disp.push_back(8'h21);
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_rd_wready: got %b required 1", cpu_ready); end
    e.addr = 15'h100; e.data = 8'hAB;
    exp_wr.push_back(e);
    step();
    cpu_we = 1'b0;
    exp_cpu.push_back(8'hAB);
`ifdef VRAM_RAW_FWD_EN
    exp_disp.push_back(8'h21);
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_rd_fwd_ready: got %b required 1", cpu_ready); end
    step();
    cpu_valid = 1'b0;
    disp_req  = 1'b0;
`else
    for (int c = 0; c < 3; c++) begin
      exp_disp.push_back(8'h21);
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b0) begin errors++; $display("FAIL wr_rd_blocked%0d: got %b required 0", c, cpu_ready); end
      step();
    end
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_drain: got rdy=%b we=%b required 0 1", cpu_ready, mem_we);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h100) begin
      errors++;
      $display("FAIL wr_rd_issue: got rdy=%b en=%b we=%b a=%h required 1 1 0 0100", cpu_ready, mem_en, mem_we, mem_addr);
    end
    step();
    cpu_valid = 1'b0;
`endif
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_rd_done: got pending, required idle"); end
  endtask

  task automatic test_alternating();
    bit            pat_d  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit            pat_en [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] pat_a  [5] = '{15'h40, 15'h41, 15'h55, 15'h43, 15'h0};
    bit            pat_rv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit ok;
    for (int c = 0; c < 5; c++) begin
      disp_req  = pat_d[c];
      disp_addr = 15'(32'h40 + c);
      if (pat_d[c]) exp_disp.push_back(8'(32'h40 + c));
      if (c == 0) begin
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h55;
        exp_cpu.push_back(8'h55);
      end else begin
        cpu_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (mem_en !== pat_en[c] || (pat_en[c] && (mem_we !== 1'b0 || mem_addr !== pat_a[c]))) begin
        errors++;
        $display("FAIL alt_grant%0d: got en=%b we=%b a=%h required en=%b a=%h", c, mem_en, mem_we, mem_addr, pat_en[c], pat_a[c]);
      end
      checks++;
      if (cpu_rvalid !== pat_rv[c]) begin
        errors++;
        $display("FAIL alt_rvalid%0d: got %b required %b", c, cpu_rvalid, pat_rv[c]);
      end
      if (c == 0) begin
        checks++;
        if (cpu_ready !== 1'b1) begin errors++; $display("FAIL alt_accept: got %b required 1", cpu_ready); end
      end
      step();
    end
    disp_req = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alt_done: got pending, required idle"); end
  endtask

  task automatic test_reset_mid_drain();
    wfifo_entry_t e;
    disp_req  = 1'b1;
    disp_addr = 15'h22;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h77;
    exp_disp.push_back(8'h22);
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_accept: got %b required 1", cpu_ready); end
    step();
    for (int k = 0; k < 4; k++) begin
      cpu_we = 1'b1; cpu_addr = 15'(32'h500 + k); cpu_wdata = 8'(32'hC0 + k);
      exp_disp.push_back(8'h22);
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_accept%0d: got %b required 1", k, cpu_ready); end
      step();
    end
    cpu_valid = 1'b0;
    disp_req  = 1'b0;
    e.addr = 15'h500; e.data = 8'hC0;
    exp_wr.push_back(e);
    @(negedge clk);
    step();
    checks++;
    if (wfifo_count !== 3) begin errors++; $display("FAIL rst_pre_count: got %0d required 3", wfifo_count); end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, cpu_rvalid, disp_rvalid, cpu_ready} !== '0 || wfifo_count !== '0) begin
      errors++;
      $display("FAIL rst_async: got en=%b we=%b crv=%b drv=%b rdy=%b cnt=%0d required all 0", mem_en, mem_we, cpu_rvalid, disp_rvalid, cpu_ready, wfifo_count);
    end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || cpu_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_quiet%0d: got en=%b crv=%b required 0 0", c, mem_en, cpu_rvalid);
      end
      step();
    end
    checks++;
    if (vram[32'h500] !== 8'hC0) begin errors++; $display("FAIL rst_vram_done: got %h required c0", vram[32'h500]); end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (vram[32'h500 + k] !== 8'(k)) begin
        errors++;
        $display("FAIL rst_vram_discard%0d: got %h required %h", k, vram[32'h500 + k], 8'(k));
      end
    end
  endtask

`ifdef VRAM_RAW_FWD_EN
  task automatic test_raw_fwd();
    wfifo_entry_t e;
    bit ok;
    logic [DW-1:0] wd [2] = '{8'h55, 8'h66};
    disp_req  = 1'b1;
    disp_addr = 15'h23;
    for (int k = 0; k < 2; k++) begin
      cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h200; cpu_wdata = wd[k];
      exp_disp.push_back(8'h23);
      e.addr = 15'h200; e.data = wd[k];
      exp_wr.push_back(e);
      step();
    end
    cpu_we = 1'b0;
    exp_disp.push_back(8'h23);
    exp_cpu.push_back(8'h66);
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || mem_addr !== 15'h23) begin
      errors++;
      $display("FAIL fwd_accept: got rdy=%b a=%h required 1 0023", cpu_ready, mem_addr);
    end
    step();
    cpu_valid = 1'b0;
    exp_disp.push_back(8'h23);
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h66 || mem_addr !== 15'h23) begin
      errors++;
      $display("FAIL fwd_data: got rv=%b d=%h a=%h required 1 66 0023", cpu_rvalid, cpu_rdata, mem_addr);
    end
    step();
    disp_req = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fwd_drain: got pending, required idle"); end
    checks++;
    if (vram[32'h200] !== 8'h66) begin errors++; $display("FAIL fwd_vram: got %h required 66", vram[32'h200]); end
  endtask
`endif

  initial begin
    fork
      run_monitor();
    join_none
    #1;
    test_reset();
    test_disp_fetch();
    test_back_to_back();
    test_write_then_read();
    test_alternating();
    test_reset_mid_drain();
`ifdef VRAM_RAW_FWD_EN
    test_raw_fwd();
`endif
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
